jtframe_frac_cen_multi: RTL

//  Multi-channel fractional clock-enable generator. Each channel pulses cen at
//  an average rate of clk*N/M, with N/M programmable at run time. An optional
//  180-degree shifted cenb pulse is available per channel. Replaces fixed

---
 rtl/jtframe_cen_pkg.sv | 14 +
 rtl/jtframe_frac_cen_ch.sv | 85 ++++++++
 rtl/jtframe_frac_cen_multi.sv | 51 +++++
 3 files changed

// File: rtl/jtframe_cen_pkg.sv
// Shared constants and the N/M clamp for the fractional clock-enable generator.
// The optional cenb output is enabled by defining JTFRAME_FRAC_CENB_EN.
`ifndef JTFRAME_CEN_PKG_SV
`define JTFRAME_CEN_PKG_SV

// Effective numerator: an N above M saturates to M, so the channel fires every cycle.
`define JTFRAME_CEN_CLAMP(n, m) (((n) > (m)) ? (m) : (n))

package jtframe_cen_pkg;
    localparam int CEN_DEF_N = 1;
    localparam int CEN_DEF_M = 2;
endpackage

`endif

// File: rtl/jtframe_frac_cen_ch.sv
// One fractional clock-enable channel: accumulator, clamp and cen/cenb compare.
// The cenb comparators exist only when JTFRAME_FRAC_CENB_EN is defined.
module jtframe_frac_cen_ch
    import jtframe_cen_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEF_N = CEN_DEF_N,
    parameter int DEF_M = CEN_DEF_M
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         sync,
    input  logic         we,
    input  logic [W-1:0] cfg_n,
    input  logic [W-1:0] cfg_m,
    output logic         cen,
    output logic         cenb
);

    typedef struct packed {
        logic [W-1:0] n;
        logic [W-1:0] m;
    } cfg_t;

    cfg_t         cfg;
    logic [W-1:0] acc;
    logic [W-1:0] n_eff;
    logic [W:0]   s;
    logic [W:0]   s_m;
    logic         hit;
    logic         hitb;

    // acc < m always holds, so the W+1-bit sum cannot overflow.
    always_comb begin
        n_eff = `JTFRAME_CEN_CLAMP(cfg.n, cfg.m);
        s     = {1'b0, acc} + {1'b0, n_eff};
        s_m   = s - {1'b0, cfg.m};
        hit   = (s >= {1'b0, cfg.m});
    end

`ifdef JTFRAME_FRAC_CENB_EN
    logic [W-1:0] h;

    // cenb fires when the accumulator crosses half of M, either directly
    // or just after wrapping past M.
    always_comb begin
        h    = cfg.m >> 1;
        hitb = ((acc < h) && (s >= {1'b0, h})) || (hit && (s_m >= {1'b0, h}));
    end
`else
    assign hitb = 1'b0;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of acc and cfg, which is what gives the clean 1-clk latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            cfg.n <= W'(DEF_N);
            cfg.m <= W'(DEF_M);
            cen   <= 1'b0;
            cenb  <= 1'b0;
        end else begin
            cen  <= 1'b0;
            cenb <= 1'b0;
            if (we) begin
                cfg.n <= cfg_n;
                cfg.m <= cfg_m;
            end
            if (sync || we) begin
                acc <= '0;
            end else if (!hold) begin
                if (cfg.m == '0) begin
                    acc <= '0;
                end else begin
                    acc  <= hit ? s_m[W-1:0] : s[W-1:0];
                    cen  <= hit;
                    cenb <= hitb;
                end
            end
        end
    end

endmodule

// File: rtl/jtframe_frac_cen_multi.sv
// Multi-channel fractional clock enable: cfg decode, hold/sync fan-out, output packing.
// Define JTFRAME_FRAC_CENB_EN to build the half-period-shifted cenb outputs.
module jtframe_frac_cen_multi
    import jtframe_cen_pkg::*;
#(
    parameter  int CH    = 2,
    parameter  int W     = 16,
    parameter  int DEF_N = CEN_DEF_N,
    parameter  int DEF_M = CEN_DEF_M,
    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           hold,
    input  logic           sync,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [W-1:0]   cfg_n,
    input  logic [W-1:0]   cfg_m,
    output logic [CH-1:0]  cen,
    output logic [CH-1:0]  cenb
);

    logic [CH-1:0] we_ch;

    // Channel numbers at or above CH match no decoder output and are dropped.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            we_ch[i] = cfg_we && (cfg_ch == CHW'(i));
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        jtframe_frac_cen_ch #(
            .W     (W),
            .DEF_N (DEF_N),
            .DEF_M (DEF_M)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .hold  (hold),
            .sync  (sync),
            .we    (we_ch[i]),
            .cfg_n (cfg_n),
            .cfg_m (cfg_m),
            .cen   (cen[i]),
            .cenb  (cenb[i])
        );
    end

endmodule
